// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: RV32I funct3 width codes,
// controller state encoding, the captured request payload and the
// request legality rule.
package lsu_pkg;

  // Load width/sign codes
  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;

  // Store width codes
  localparam logic [2:0] SB  = 3'b000;
  localparam logic [2:0] SH  = 3'b001;
  localparam logic [2:0] SW  = 3'b010;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WR   = 2'd2,
    ST_RESP = 2'd3
  } lsu_state_e;

  typedef struct packed {
    logic        write;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
  } lsu_req_t;

  // Illegal width code, store with a load-only code, or misaligned half/word
  function automatic logic lsu_illegal(input logic       write,
                                       input logic [2:0] funct3,
                                       input logic [1:0] addr_lo);
    logic bad;
    bad = 1'b0;
    if (funct3 == 3'b011 || funct3 == 3'b110 || funct3 == 3'b111) bad = 1'b1;
    if (write && !(funct3 == SB || funct3 == SH || funct3 == SW)) bad = 1'b1;
    if (funct3[1:0] == 2'b01 && addr_lo[0]) bad = 1'b1;
    if (funct3[1:0] == 2'b10 && addr_lo != 2'b00) bad = 1'b1;
    return bad;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic for the load/store unit.
//   word_i       : memory word read during RD
//   funct3_i     : width/sign code of the captured request
//   byte_off_i   : byte address bits [1:0]
//   wdata_i      : store data (rs2)
//   load_data_o  : selected byte/halfword/word, sign- or zero-extended
//   store_word_o : word_i with the lanes chosen by the store width replaced
module lsu_align
  import lsu_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  byte_off_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] load_data_o,
  output logic [31:0] store_word_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Load extract and extend
  always_comb begin
    byte_sel    = 8'h00;
    half_sel    = byte_off_i[1] ? word_i[31:16] : word_i[15:0];
    load_data_o = '0;
    case (byte_off_i)
      2'd0:    byte_sel = word_i[7:0];
      2'd1:    byte_sel = word_i[15:8];
      2'd2:    byte_sel = word_i[23:16];
      default: byte_sel = word_i[31:24];
    endcase
    case (funct3_i)
      LB:      load_data_o = {{24{byte_sel[7]}}, byte_sel};
      LH:      load_data_o = {{16{half_sel[15]}}, half_sel};
      LW:      load_data_o = word_i;
      LBU:     load_data_o = {24'h000000, byte_sel};
      LHU:     load_data_o = {16'h0000, half_sel};
      default: load_data_o = '0;
    endcase
  end

  // Store merge: only the addressed lanes take new data
  always_comb begin
    store_word_o = word_i;
    case (funct3_i[1:0])
      2'b00: begin
        case (byte_off_i)
          2'd0:    store_word_o[7:0]   = wdata_i[7:0];
          2'd1:    store_word_o[15:8]  = wdata_i[7:0];
          2'd2:    store_word_o[23:16] = wdata_i[7:0];
          default: store_word_o[31:24] = wdata_i[7:0];
        endcase
      end
      2'b01: begin
        if (byte_off_i[1]) store_word_o[31:16] = wdata_i[15:0];
        else               store_word_o[15:0]  = wdata_i[15:0];
      end
      2'b10:   store_word_o = wdata_i;
      default: store_word_o = word_i;
    endcase
  end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store controller between the MEM stage and a word-wide data memory.
// Every access reads the addressed word; stores then write back the merged
// word (read-modify-write), so sub-word stores need no byte enables.
//   clock, reset             : rising-edge clock, synchronous active-low reset
//   req_valid / req_ready    : request handshake (ready only in IDLE)
//   req_write, req_funct3,
//   req_addr, req_wdata      : request payload
//   resp_valid, resp_rdata,
//   resp_err                 : one-cycle completion with load data / error
//   stall                    : hold the pipeline while a request is pending
//   mem_addr, mem_read,
//   mem_write, mem_wdata,
//   mem_rdata                : data memory port (word index, comb read data)
module lsu_ctrl
  import lsu_pkg::*;
#(
  parameter int unsigned ADDR_W = 10
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        stall,
  output logic [31:0] mem_addr,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  // Word index keeps ADDR_W bits above the byte offset; higher bits wrap
  localparam logic [31:0] WORD_MASK = 32'((64'd1 << ADDR_W) - 64'd1);

  lsu_state_e  state_q, state_d;
  lsu_req_t    req_q, req_d;
  logic        err_q, err_d;
  logic [31:0] rdata_q, rdata_d;

  logic [31:0] word_idx;
  logic [31:0] load_data;
  logic [31:0] store_word;

  assign word_idx = (req_q.addr >> 2) & WORD_MASK;
  assign stall    = (state_q != ST_IDLE) || (req_valid && state_q == ST_IDLE);

  lsu_align u_align (
    .word_i       (rdata_q),
    .funct3_i     (req_q.funct3),
    .byte_off_i   (req_q.addr[1:0]),
    .wdata_i      (req_q.wdata),
    .load_data_o  (load_data),
    .store_word_o (store_word)
  );

  // State and captured-data registers
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      req_q   <= '0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

  // Next state and state-decoded outputs
  always_comb begin
    state_d    = state_q;
    req_d      = req_q;
    err_d      = err_q;
    rdata_d    = rdata_q;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    resp_rdata = '0;
    resp_err   = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    case (state_q)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          req_d.write  = req_write;
          req_d.funct3 = req_funct3;
          req_d.addr   = req_addr;
          req_d.wdata  = req_wdata;
          err_d        = lsu_illegal(req_write, req_funct3, req_addr[1:0]);
          // Illegal requests skip memory entirely
          state_d      = err_d ? ST_RESP : ST_RD;
        end
      end
      ST_RD: begin
        mem_read = 1'b1;
        mem_addr = word_idx;
        rdata_d  = mem_rdata;
        state_d  = req_q.write ? ST_WR : ST_RESP;
      end
      ST_WR: begin
        // A reset landing on this edge must not commit the write
        mem_write = reset;
        mem_addr  = word_idx;
        mem_wdata = reset ? store_word : '0;
        state_d   = ST_RESP;
      end
      ST_RESP: begin
        resp_valid = 1'b1;
        resp_err   = err_q;
        if (!err_q && !req_q.write) resp_rdata = load_data;
        state_d    = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Bench for lsu_ctrl: directed scenarios plus randomized transactions
// checked against an arithmetic reference model and a shadow memory.
module tb_lsu_ctrl;

  logic        clock = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        stall;
  logic [31:0] mem_addr;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  int checks   = 0;
  int failures = 0;

  always #5 clock = ~clock;

  lsu_ctrl #(.ADDR_W(10)) dut (
    .clock      (clock),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .stall      (stall),
    .mem_addr   (mem_addr),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  // Data memory: combinational read, write on the rising edge
  logic [31:0] mem     [1024];
  logic [31:0] ref_mem [1024];
  bit          mem_init_done;

  function automatic logic [31:0] seed_word(input int i);
    return (32'(i) * 32'h9E37_79B1) ^ 32'h5A5A_0000;
  endfunction

  always @(posedge clock) begin
    if (!mem_init_done) begin
      for (int i = 0; i < 1024; i++) mem[i] <= seed_word(i);
      mem_init_done <= 1'b1;
    end else if (mem_write) begin
      mem[mem_addr[9:0]] <= mem_wdata;
    end
  end
  assign mem_rdata = mem[mem_addr[9:0]];

  // ---------------- reference model ----------------
  function automatic logic ref_illegal(input logic wr, input logic [2:0] f3, input logic [31:0] a);
    if (f3 == 3 || f3 == 6 || f3 == 7) return 1'b1;
    if (wr && f3 > 2) return 1'b1;
    if (f3 % 4 == 1 && a % 2 != 0) return 1'b1;
    if (f3 % 4 == 2 && a % 4 != 0) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] w, input logic [2:0] f3, input logic [31:0] a);
    int unsigned off = a % 4;
    logic [31:0] v;
    v = w;
    if (f3 == 0 || f3 == 4) begin
      v = (w >> (8 * off)) & 32'hFF;
      if (f3 == 0 && v >= 128) v = v - 256;
    end else if (f3 == 1 || f3 == 5) begin
      v = (w >> (16 * (off / 2))) & 32'hFFFF;
      if (f3 == 1 && v >= 32768) v = v - 65536;
    end
    return v;
  endfunction

  function automatic logic [31:0] ref_store(input logic [31:0] w, input logic [2:0] f3,
                                            input logic [31:0] a, input logic [31:0] d);
    int unsigned off = a % 4;
    int unsigned sh;
    logic [31:0] mask;
    if (f3 == 0)      begin mask = 32'hFF;       sh = 8 * off; end
    else if (f3 == 1) begin mask = 32'hFFFF;     sh = 16 * (off / 2); end
    else              begin mask = 32'hFFFFFFFF; sh = 0; end
    mask = mask << sh;
    return (w & ~mask) | ((d << sh) & mask);
  endfunction

  // ---------------- transaction driver (records observations) ----------------
  int          o_resp_cyc, o_wr_cyc, o_rd_cnt, o_wr_cnt;
  logic [31:0] o_rdata, o_rd_addr, o_wr_addr, o_wr_data;
  logic        o_err;

  task automatic run_req(input logic wr, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
    bit ready_seen;
    o_resp_cyc = -1; o_wr_cyc = -1; o_rd_cnt = 0; o_wr_cnt = 0;
    o_rdata = '0; o_rd_addr = '0; o_wr_addr = '0; o_wr_data = '0; o_err = 1'b0;
    req_write = wr; req_funct3 = f3; req_addr = a; req_wdata = d; req_valid = 1'b1;
    ready_seen = 0;
    for (int w = 0; w < 10; w++) begin
      #1;
      if (req_ready) begin ready_seen = 1; break; end
      @(negedge clock);
    end
    if (!ready_seen) begin req_valid = 1'b0; return; end
    @(posedge clock);
    #1 req_valid = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clock);
      if (mem_read) begin o_rd_cnt++; o_rd_addr = mem_addr; end
      if (mem_write) begin o_wr_cnt++; o_wr_cyc = c; o_wr_addr = mem_addr; o_wr_data = mem_wdata; end
      if (resp_valid) begin o_resp_cyc = c; o_rdata = resp_rdata; o_err = resp_err; break; end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    reset = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL rst_req_ready got=%b exp=1", req_ready); end
    checks++; if (resp_valid !== 1'b0) begin failures++; $display("FAIL rst_resp_valid got=%b exp=0", resp_valid); end
    checks++; if (resp_rdata !== 32'h0) begin failures++; $display("FAIL rst_resp_rdata got=%h exp=0", resp_rdata); end
    checks++; if (resp_err !== 1'b0) begin failures++; $display("FAIL rst_resp_err got=%b exp=0", resp_err); end
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL rst_stall got=%b exp=0", stall); end
    checks++; if (mem_read !== 1'b0 || mem_write !== 1'b0) begin failures++; $display("FAIL rst_mem_ctl got=%b%b exp=00", mem_read, mem_write); end
    checks++; if (mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin failures++; $display("FAIL rst_mem_bus got=%h/%h exp=0/0", mem_addr, mem_wdata); end
    reset = 1'b1;
  endtask

  task automatic test_store_word;
    run_req(1'b1, 3'b010, 32'h10, 32'hDEADBEEF);
    checks++; if (o_wr_cyc !== 2) begin failures++; $display("FAIL sw_write_cycle got=%0d exp=2", o_wr_cyc); end
    checks++; if (o_wr_addr !== 32'd4) begin failures++; $display("FAIL sw_mem_addr got=%h exp=4", o_wr_addr); end
    checks++; if (o_wr_data !== 32'hDEADBEEF) begin failures++; $display("FAIL sw_mem_wdata got=%h exp=deadbeef", o_wr_data); end
    checks++; if (o_resp_cyc !== 3) begin failures++; $display("FAIL sw_resp_cycle got=%0d exp=3", o_resp_cyc); end
    checks++; if (o_err !== 1'b0) begin failures++; $display("FAIL sw_resp_err got=%b exp=0", o_err); end
    ref_mem[4] = 32'hDEADBEEF;
    @(negedge clock);
    checks++; if (resp_valid !== 1'b0) begin failures++; $display("FAIL sw_resp_one_cycle got=%b exp=0", resp_valid); end
  endtask

  task automatic test_loads;
    run_req(1'b0, 3'b000, 32'h13, 32'h0);
    checks++; if (o_resp_cyc !== 2) begin failures++; $display("FAIL lb_resp_cycle got=%0d exp=2", o_resp_cyc); end
    checks++; if (o_rdata !== 32'hFFFFFFDE) begin failures++; $display("FAIL lb_rdata got=%h exp=ffffffde", o_rdata); end
    run_req(1'b0, 3'b100, 32'h13, 32'h0);
    checks++; if (o_rdata !== 32'h000000DE) begin failures++; $display("FAIL lbu_rdata got=%h exp=000000de", o_rdata); end
    run_req(1'b0, 3'b001, 32'h10, 32'h0);
    checks++; if (o_rdata !== 32'hFFFFBEEF) begin failures++; $display("FAIL lh_rdata got=%h exp=ffffbeef", o_rdata); end
    checks++; if (o_wr_cnt !== 0) begin failures++; $display("FAIL lh_no_write got=%0d exp=0", o_wr_cnt); end
  endtask

  task automatic test_sub_stores;
    run_req(1'b1, 3'b000, 32'h11, 32'h00000055);
    checks++; if (o_wr_data !== 32'hDEAD55EF) begin failures++; $display("FAIL sb_mem_wdata got=%h exp=dead55ef", o_wr_data); end
    run_req(1'b1, 3'b010, 32'h10, 32'hDEADBEEF);
    run_req(1'b1, 3'b001, 32'h12, 32'h00001234);
    checks++; if (o_wr_data !== 32'h1234BEEF) begin failures++; $display("FAIL sh_mem_wdata got=%h exp=1234beef", o_wr_data); end
    ref_mem[4] = 32'h1234BEEF;
    // Upper address bits wrap onto the same word
    run_req(1'b0, 3'b010, 32'h1010, 32'h0);
    checks++; if (o_rd_addr !== 32'd4) begin failures++; $display("FAIL wrap_mem_addr got=%h exp=4", o_rd_addr); end
    checks++; if (o_rdata !== 32'h1234BEEF) begin failures++; $display("FAIL wrap_rdata got=%h exp=1234beef", o_rdata); end
  endtask

  task automatic test_errors;
    logic        ew [3] = '{1'b0, 1'b1, 1'b0};
    logic [2:0]  ef [3] = '{3'b010, 3'b001, 3'b011};
    logic [31:0] ea [3] = '{32'h12, 32'h13, 32'h20};
    for (int k = 0; k < 3; k++) begin
      run_req(ew[k], ef[k], ea[k], 32'hFFFF_FFFF);
      checks++; if (o_err !== 1'b1) begin failures++; $display("FAIL err%0d_flag got=%b exp=1", k, o_err); end
      checks++; if (o_resp_cyc !== 1) begin failures++; $display("FAIL err%0d_resp_cycle got=%0d exp=1", k, o_resp_cyc); end
      checks++; if (o_rd_cnt + o_wr_cnt !== 0) begin failures++; $display("FAIL err%0d_mem_access got=%0d exp=0", k, o_rd_cnt + o_wr_cnt); end
      checks++; if (o_rdata !== 32'h0) begin failures++; $display("FAIL err%0d_rdata got=%h exp=0", k, o_rdata); end
    end
  endtask

  task automatic test_reset_abort;
    bit saw_wr, saw_resp;
    for (int ph = 0; ph < 2; ph++) begin
      req_write = 1'b1; req_funct3 = 3'b010; req_addr = 32'h20;
      req_wdata = 32'hA5A5_0000 | 32'(ph); req_valid = 1'b1;
      for (int w = 0; w < 10; w++) begin
        #1;
        if (req_ready) break;
        @(negedge clock);
      end
      @(posedge clock);
      #1 req_valid = 1'b0;
      saw_wr = 0; saw_resp = 0;
      @(negedge clock);
      if (ph == 1) @(negedge clock);
      reset = 1'b0;
      #1;
      if (mem_write) saw_wr = 1;
      if (resp_valid) saw_resp = 1;
      @(posedge clock);
      #1 reset = 1'b1;
      for (int c = 0; c < 4; c++) begin
        @(negedge clock);
        if (mem_write) saw_wr = 1;
        if (resp_valid) saw_resp = 1;
      end
      checks++; if (saw_wr !== 1'b0) begin failures++; $display("FAIL abort%0d_no_write got=%b exp=0", ph, saw_wr); end
      checks++; if (saw_resp !== 1'b0) begin failures++; $display("FAIL abort%0d_no_resp got=%b exp=0", ph, saw_resp); end
      checks++; if (mem[8] !== ref_mem[8]) begin failures++; $display("FAIL abort%0d_mem got=%h exp=%h", ph, mem[8], ref_mem[8]); end
      checks++; if (req_ready !== 1'b1 || stall !== 1'b0) begin failures++; $display("FAIL abort%0d_idle got=%b%b exp=10", ph, req_ready, stall); end
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] d [3];
    int acc = 0, resps = 0, writes = 0, stall_lo = 0, i = 0;
    bit take;
    for (int k = 0; k < 3; k++) d[k] = $urandom;
    req_write = 1'b1; req_funct3 = 3'b010; req_addr = 32'h40; req_wdata = d[0]; req_valid = 1'b1;
    for (int c = 0; c < 40; c++) begin
      #1;
      if (!stall) stall_lo++;
      if (resp_valid) resps++;
      if (mem_write) writes++;
      if (resps == 3) break;
      take = req_valid && req_ready;
      @(posedge clock);
      #1;
      if (take) begin
        acc++; i++;
        if (i < 3) begin req_addr = 32'h40 + 32'(4 * i); req_wdata = d[i]; end
        else req_valid = 1'b0;
      end
      @(negedge clock);
    end
    req_valid = 1'b0;
    checks++; if (acc !== 3) begin failures++; $display("FAIL b2b_accepts got=%0d exp=3", acc); end
    checks++; if (resps !== 3) begin failures++; $display("FAIL b2b_resps got=%0d exp=3", resps); end
    checks++; if (writes !== 3) begin failures++; $display("FAIL b2b_writes got=%0d exp=3", writes); end
    checks++; if (stall_lo !== 0) begin failures++; $display("FAIL b2b_stall_low got=%0d exp=0", stall_lo); end
    for (int k = 0; k < 3; k++) begin
      ref_mem[16 + k] = d[k];
      checks++; if (mem[16 + k] !== d[k]) begin failures++; $display("FAIL b2b_mem%0d got=%h exp=%h", k, mem[16 + k], d[k]); end
    end
  endtask

  task automatic test_random;
    logic        wr, ill;
    logic [2:0]  f3;
    logic [31:0] a, d, exp_w;
    int          idx, bad_words;
    for (int n = 0; n < 60; n++) begin
      wr  = 1'($urandom_range(0, 1));
      f3  = 3'($urandom_range(0, 7));
      a   = ($urandom & 32'hFFFF_F000) | (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
      d   = $urandom;
      ill = ref_illegal(wr, f3, a);
      idx = int'((a >> 2) % 1024);
      run_req(wr, f3, a, d);
      checks++; if (o_err !== ill) begin failures++; $display("FAIL rnd%0d_err got=%b exp=%b", n, o_err, ill); end
      if (ill) begin
        checks++; if (o_resp_cyc !== 1 || o_rd_cnt + o_wr_cnt !== 0) begin failures++; $display("FAIL rnd%0d_err_timing got=%0d/%0d exp=1/0", n, o_resp_cyc, o_rd_cnt + o_wr_cnt); end
      end else if (!wr) begin
        exp_w = ref_load(ref_mem[idx], f3, a);
        checks++; if (o_resp_cyc !== 2) begin failures++; $display("FAIL rnd%0d_ld_cycle got=%0d exp=2", n, o_resp_cyc); end
        checks++; if (o_rdata !== exp_w) begin failures++; $display("FAIL rnd%0d_ld_data got=%h exp=%h", n, o_rdata, exp_w); end
        checks++; if (o_rd_addr !== 32'(idx)) begin failures++; $display("FAIL rnd%0d_ld_addr got=%h exp=%h", n, o_rd_addr, idx); end
      end else begin
        exp_w = ref_store(ref_mem[idx], f3, a, d);
        checks++; if (o_resp_cyc !== 3 || o_wr_cyc !== 2) begin failures++; $display("FAIL rnd%0d_st_timing got=%0d/%0d exp=3/2", n, o_resp_cyc, o_wr_cyc); end
        checks++; if (o_wr_addr !== 32'(idx)) begin failures++; $display("FAIL rnd%0d_st_addr got=%h exp=%h", n, o_wr_addr, idx); end
        checks++; if (o_wr_data !== exp_w) begin failures++; $display("FAIL rnd%0d_st_data got=%h exp=%h", n, o_wr_data, exp_w); end
        checks++; if (o_rdata !== 32'h0) begin failures++; $display("FAIL rnd%0d_st_rdata got=%h exp=0", n, o_rdata); end
        ref_mem[idx] = exp_w;
      end
    end
    bad_words = 0;
    for (int k = 0; k < 1024; k++) if (mem[k] !== ref_mem[k]) bad_words++;
    checks++; if (bad_words !== 0) begin failures++; $display("FAIL rnd_mem_image got=%0d exp=0 differing words", bad_words); end
  endtask

  initial begin
    reset = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_funct3 = 3'b000;
    req_addr = '0; req_wdata = '0;
    for (int i = 0; i < 1024; i++) ref_mem[i] = seed_word(i);
    test_reset();
    test_store_word();
    test_loads();
    test_sub_stores();
    test_errors();
    test_reset_abort();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule
